// File: rtl/counter7sd_pkg.sv
// Segment encodings and BCD-to-7-segment decode shared by the multi-digit counter.
// Segment order is {g,f,e,d,c,b,a}; a 1 lights the segment.
package counter7sd_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b0111111;
    localparam seg_t SEG_1     = 7'b0000110;
    localparam seg_t SEG_2     = 7'b1011011;
    localparam seg_t SEG_3     = 7'b1001111;
    localparam seg_t SEG_4     = 7'b1100110;
    localparam seg_t SEG_5     = 7'b1101101;
    localparam seg_t SEG_6     = 7'b1111101;
    localparam seg_t SEG_7     = 7'b0000111;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1101111;
    localparam seg_t SEG_BLANK = 7'b0000000;

    // Codes above 9 cannot occur in a healthy counter; show them dark.
    function automatic seg_t bcd_to_seg(input bcd_t bcd);
        case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/counter7sd_multi_bcd_decade.sv
// One BCD decade of the up/down counter. carry_out is combinational so a whole
// chain of decades ripples its carry or borrow within a single clock cycle.
module bcd_decade
    import counter7sd_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic dir,
    output bcd_t q,
    output logic carry_out
);

    assign carry_out = en && (dir ? (q == 4'd0) : (q == 4'd9));

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= 4'd0;
        end else if (en) begin
            if (dir)
                q <= (q == 4'd0) ? 4'd9 : q - 4'd1;
            else
                q <= (q >= 4'd9) ? 4'd0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/counter7sd_multi.sv
// Multi-digit BCD up/down counter with prescaler and multiplexed 7-segment scan.
// Define LEADING_ZERO_BLANK_EN to blank zero decades above the most significant nonzero one.
module counter7sd_multi
    import counter7sd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1,
    parameter int SCAN_DIV = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pause,
    input  logic                  reverse,
    output logic [6:0]            data,
    output logic [DIGITS-1:0]     digit,
    output logic [4*DIGITS-1:0]   value,
    output logic                  wrap
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;

    logic [PW-1:0] presc;
    logic          tick;
    logic [SW-1:0] scan_cnt;
    logic [IW-1:0] scan_idx;
    logic [DIGITS:0] chain;
    bcd_t          sel_bcd;
    seg_t          seg_next;

    assign tick     = !pause && (presc == PW'(PRESCALE - 1));
    assign chain[0] = tick;

    always_ff @(posedge clock) begin
        if (reset)
            presc <= '0;
        else if (!pause)
            presc <= tick ? '0 : presc + 1'b1;
    end

    // chain[i+1] is decade i rolling over, which enables decade i+1.
    for (genvar i = 0; i < DIGITS; i++) begin : g_decade
        bcd_decade u_decade (
            .clock     (clock),
            .reset     (reset),
            .en        (chain[i]),
            .dir       (reverse),
            .q         (value[4*i +: 4]),
            .carry_out (chain[i+1])
        );
    end

    always_ff @(posedge clock) begin
        if (reset)
            wrap <= 1'b0;
        else
            wrap <= chain[DIGITS];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic upper_zero;
    logic sel_blank;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sel_bcd    = '0;
        upper_zero = 1'b1;
        sel_blank  = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (value[4*i +: 4] == 4'd0);
            if (scan_idx == IW'(i)) begin
                sel_bcd   = value[4*i +: 4];
                sel_blank = (i != 0) && upper_zero;
            end
        end
        seg_next = sel_blank ? SEG_BLANK : bcd_to_seg(sel_bcd);
    end
`else
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sel_bcd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx == IW'(i))
                sel_bcd = value[4*i +: 4];
        end
        seg_next = bcd_to_seg(sel_bcd);
    end
`endif

    // digit and data are registered together so they always refer to the same decade.
    always_ff @(posedge clock) begin
        if (reset) begin
            digit <= DIGITS'(1);
            data  <= SEG_0;
        end else begin
            digit <= DIGITS'(1) << scan_idx;
            data  <= seg_next;
        end
    end

endmodule

// File: tb/tb_counter7sd_multi.sv
// Self-checking bench for counter7sd_multi: integer-count reference model plus
// a second instance with PRESCALE=5 for prescaler checks.
module tb_counter7sd_multi;

    localparam int D  = 4;
    localparam int SD = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset   = 1'b1;
    logic        pause   = 1'b0;
    logic        reverse = 1'b0;
    logic [6:0]  data;
    logic [3:0]  digit;
    logic [15:0] value;
    logic        wrap;

    logic        reset2 = 1'b1;
    logic [6:0]  data2;
    logic [3:0]  digit2;
    logic [15:0] value2;
    logic        wrap2;

    counter7sd_multi #(.DIGITS(D), .PRESCALE(1), .SCAN_DIV(SD)) dut (
        .clock   (clock),
        .reset   (reset),
        .pause   (pause),
        .reverse (reverse),
        .data    (data),
        .digit   (digit),
        .value   (value),
        .wrap    (wrap)
    );

    counter7sd_multi #(.DIGITS(4), .PRESCALE(5), .SCAN_DIV(4)) dut2 (
        .clock   (clock),
        .reset   (reset2),
        .pause   (1'b0),
        .reverse (1'b0),
        .data    (data2),
        .digit   (digit2),
        .value   (value2),
        .wrap    (wrap2)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference model: count as a plain integer, scan as elapsed cycles.
    int         m_cnt = 0;
    int         m_k   = 0;
    logic [3:0] m_digit = 4'b0001;
    logic [6:0] m_data  = 7'h3F;
    logic       m_wrap  = 1'b0;

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        for (int i = 0; i < 4; i++)
            r[4*i +: 4] = 4'((n / (10 ** i)) % 10);
        return r;
    endfunction

    task automatic step();
        int  idx;
        bit  tick;
        @(posedge clock);
        if (reset) begin
            m_cnt = 0; m_k = 0; m_digit = 4'b0001; m_data = seg_tab[0]; m_wrap = 1'b0;
        end else begin
            idx     = (m_k / SD) % D;
            m_digit = 4'(1 << idx);
            m_data  = seg_tab[(m_cnt / (10 ** idx)) % 10];
`ifdef LEADING_ZERO_BLANK_EN
            if (idx > 0 && m_cnt < 10 ** idx) m_data = 7'h00;
`endif
            m_k++;
            tick   = !pause;
            m_wrap = tick && (reverse ? (m_cnt == 0) : (m_cnt == 9999));
            if (tick) m_cnt = reverse ? (m_cnt + 9999) % 10000 : (m_cnt + 1) % 10000;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; pause = 1'b0; reverse = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (value !== 16'h0000) begin errors++; $display("FAIL reset_value: got %h expected 0000", value); end
        checks++; if (digit !== 4'b0001) begin errors++; $display("FAIL reset_digit: got %b expected 0001", digit); end
        checks++; if (data !== 7'b0111111) begin errors++; $display("FAIL reset_data: got %b expected 0111111", data); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
    endtask

    task automatic test_up_wrap();
        int wraps = 0;
        do_reset();
        repeat (10000) begin
            step();
            checks++; if (value !== to_bcd(m_cnt)) begin errors++; $display("FAIL up_value: got %h expected %h", value, to_bcd(m_cnt)); end
            checks++; if (wrap !== m_wrap) begin errors++; $display("FAIL up_wrap: got %b expected %b", wrap, m_wrap); end
            checks++; if (digit !== m_digit) begin errors++; $display("FAIL up_digit: got %b expected %b", digit, m_digit); end
            checks++; if (data !== m_data) begin errors++; $display("FAIL up_data: got %b expected %b", data, m_data); end
            if (wrap === 1'b1) wraps++;
        end
        checks++; if (value !== 16'h0000) begin errors++; $display("FAIL up_end_value: got %h expected 0000", value); end
        checks++; if (wraps != 1) begin errors++; $display("FAIL up_wrap_count: got %0d expected 1", wraps); end
    endtask

    task automatic test_down();
        do_reset();
        reverse = 1'b1;
        step();
        checks++; if (value !== 16'h9999) begin errors++; $display("FAIL down_first: got %h expected 9999", value); end
        checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL down_wrap: got %b expected 1", wrap); end
        repeat (10) step();
        checks++; if (value !== 16'h9989) begin errors++; $display("FAIL down_ten: got %h expected 9989", value); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL down_wrap_clear: got %b expected 0", wrap); end
        reverse = 1'b0;
        step();
        checks++; if (value !== 16'h9990) begin errors++; $display("FAIL reversal: got %h expected 9990", value); end
    endtask

    task automatic test_pause();
        do_reset();
        repeat (42) step();
        checks++; if (value !== 16'h0042) begin errors++; $display("FAIL pause_start: got %h expected 0042", value); end
        pause = 1'b1;
        repeat (20) begin
            step();
            checks++; if (value !== 16'h0042) begin errors++; $display("FAIL pause_hold: got %h expected 0042", value); end
            checks++; if (digit !== m_digit) begin errors++; $display("FAIL pause_scan: got %b expected %b", digit, m_digit); end
        end
        pause = 1'b0;
        step();
        checks++; if (value !== 16'h0043) begin errors++; $display("FAIL pause_release: got %h expected 0043", value); end
    endtask

    task automatic test_display();
        logic [6:0] exp;
        do_reset();
        repeat (307) step();
        pause = 1'b1;
        repeat (8) begin
            step();
            case (m_digit)
`ifdef LEADING_ZERO_BLANK_EN
                4'b1000: exp = 7'b0000000;
`else
                4'b1000: exp = 7'b0111111;
`endif
                4'b0100: exp = 7'b1001111;
                4'b0010: exp = 7'b0111111;
                default: exp = 7'b0000111;
            endcase
            checks++; if (digit !== m_digit) begin errors++; $display("FAIL disp_digit: got %b expected %b", digit, m_digit); end
            checks++; if (data !== exp) begin errors++; $display("FAIL disp_data: digit %b got %b expected %b", m_digit, data, exp); end
        end
        pause = 1'b0;
    endtask

    task automatic test_prescaler();
        reset2 = 1'b1;
        step(); step();
        reset2 = 1'b0;
        checks++; if (digit2 !== 4'b0001) begin errors++; $display("FAIL pre_reset_digit: got %b expected 0001", digit2); end
        checks++; if (data2 !== 7'b0111111) begin errors++; $display("FAIL pre_reset_data: got %b expected 0111111", data2); end
        for (int k = 1; k <= 25; k++) begin
            step();
            checks++; if (value2 !== to_bcd(k / 5)) begin errors++; $display("FAIL pre_value: cycle %0d got %h expected %h", k, value2, to_bcd(k / 5)); end
        end
        step(); step();
        reset2 = 1'b1;
        step();
        reset2 = 1'b0;
        checks++; if (value2 !== 16'h0000) begin errors++; $display("FAIL pre_midreset: got %h expected 0000", value2); end
        checks++; if (wrap2 !== 1'b0) begin errors++; $display("FAIL pre_wrap: got %b expected 0", wrap2); end
    endtask

    task automatic test_random();
        do_reset();
        repeat (3000) begin
            pause   = ($urandom_range(0, 3) == 0);
            reverse = 1'($urandom_range(0, 1));
            reset   = ($urandom_range(0, 199) == 0);
            step();
            checks++; if (value !== to_bcd(m_cnt)) begin errors++; $display("FAIL rnd_value: got %h expected %h", value, to_bcd(m_cnt)); end
            checks++; if (wrap !== m_wrap) begin errors++; $display("FAIL rnd_wrap: got %b expected %b", wrap, m_wrap); end
            checks++; if (digit !== m_digit) begin errors++; $display("FAIL rnd_digit: got %b expected %b", digit, m_digit); end
            checks++; if (data !== m_data) begin errors++; $display("FAIL rnd_data: got %b expected %b", data, m_data); end
        end
        reset = 1'b0; pause = 1'b0; reverse = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down();
        test_pause();
        test_display();
        test_prescaler();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
